// File: rtl/addr_trans_if.sv
// Request/response handshake and TLB search port bundle for addr_trans.
interface addr_trans_if #(
  parameter int unsigned TLBNUM = 16
);
  localparam int unsigned IDXW = $clog2(TLBNUM);

  // request channel
  logic            req_valid;
  logic            req_ready;
  logic [31:0]     req_va;
  logic            req_wr;

  // TLB search port
  logic [18:0]     s_vppn;
  logic            s_va_bit12;
  logic [9:0]      s_asid;
  logic            s_found;
  logic [IDXW-1:0] s_index;
  logic [19:0]     s_ppn;
  logic [5:0]      s_ps;
  logic [1:0]      s_plv;
  logic            s_d;
  logic            s_v;

  // response channel
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_pa;
  logic [2:0]      rsp_ecode;
  logic [IDXW-1:0] rsp_index;

  modport slave (
    input  req_valid, req_va, req_wr,
    output req_ready,
    output s_vppn, s_va_bit12, s_asid,
    input  s_found, s_index, s_ppn, s_ps, s_plv, s_d, s_v,
    output rsp_valid, rsp_pa, rsp_ecode, rsp_index,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_va, req_wr,
    input  req_ready,
    input  s_vppn, s_va_bit12, s_asid,
    output s_found, s_index, s_ppn, s_ps, s_plv, s_d, s_v,
    input  rsp_valid, rsp_pa, rsp_ecode, rsp_index,
    output rsp_ready
  );
endinterface

// File: rtl/addr_trans.sv
// Virtual-to-physical address translation: direct address, DMW windows,
// then TLB lookup with exception classification. One request in flight.
module addr_trans #(
  parameter int unsigned TLBNUM = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         crmd_da,
  input  logic [1:0]   crmd_plv,
  input  logic [31:0]  dmw0,
  input  logic [31:0]  dmw1,
  input  logic [9:0]   asid,
  addr_trans_if.slave  bus
);
  localparam int unsigned IDXW = $clog2(TLBNUM);

  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;
  typedef enum logic [2:0] {
    EC_NONE = 3'd0,
    EC_TLBR = 3'd1,
    EC_PIL  = 3'd2,
    EC_PIS  = 3'd3,
    EC_PPI  = 3'd4,
    EC_PME  = 3'd5
  } ecode_t;

  state_t          state, state_nxt;
  logic [31:0]     va_r;
  logic            wr_r;
  logic [31:0]     rsp_pa_r;
  logic [2:0]      rsp_ecode_r;
  logic [IDXW-1:0] rsp_index_r;
  logic            req_ready_c;
  logic            rsp_valid_c;

  logic            dmw0_hit, dmw1_hit;
  logic [31:0]     tlb_pa;
  logic [31:0]     res_pa;
  ecode_t          res_ec;
  logic [IDXW-1:0] res_idx;

  logic            unused_bits;
  assign unused_bits = ^{dmw0[28], dmw0[24:4], dmw0[2:1],
                         dmw1[28], dmw1[24:4], dmw1[2:1]};

  assign bus.s_vppn     = va_r[31:13];
  assign bus.s_va_bit12 = va_r[12];
  assign bus.s_asid     = asid;
  assign bus.req_ready  = req_ready_c;
  assign bus.rsp_valid  = rsp_valid_c;
  assign bus.rsp_pa     = rsp_pa_r;
  assign bus.rsp_ecode  = rsp_ecode_r;
  assign bus.rsp_index  = rsp_index_r;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state logic; flush overrides every other transition
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.req_valid) state_nxt = LOOKUP;
        LOOKUP:  state_nxt = RESP;
        RESP:    if (bus.rsp_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // handshake outputs decoded from state
  always_comb begin
    req_ready_c = 1'b0;
    rsp_valid_c = 1'b0;
    case (state)
      IDLE:    req_ready_c = !flush;
      RESP:    rsp_valid_c = 1'b1;
      default: ;
    endcase
  end

  // request capture on accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      va_r <= '0;
      wr_r <= 1'b0;
    end else if (state == IDLE && bus.req_valid && req_ready_c) begin
      va_r <= bus.req_va;
      wr_r <= bus.req_wr;
    end
  end

  // translation result from TLB outputs and live CSRs
  always_comb begin
    dmw0_hit = (va_r[31:29] == dmw0[31:29]) &&
               ((crmd_plv == 2'd0 && dmw0[0]) || (crmd_plv == 2'd3 && dmw0[3]));
    dmw1_hit = (va_r[31:29] == dmw1[31:29]) &&
               ((crmd_plv == 2'd0 && dmw1[0]) || (crmd_plv == 2'd3 && dmw1[3]));
    tlb_pa   = (bus.s_ps == 6'd21) ? {bus.s_ppn[19:9], va_r[20:0]}
                                   : {bus.s_ppn, va_r[11:0]};
    res_pa   = '0;
    res_ec   = EC_NONE;
    res_idx  = '0;
    if (crmd_da) begin
      res_pa = va_r;
    end else if (dmw0_hit) begin
      res_pa = {dmw0[27:25], va_r[28:0]};
    end else if (dmw1_hit) begin
      res_pa = {dmw1[27:25], va_r[28:0]};
    end else begin
      if (!bus.s_found)                res_ec = EC_TLBR;
      else if (!bus.s_v)               res_ec = wr_r ? EC_PIS : EC_PIL;
      else if (crmd_plv > bus.s_plv)   res_ec = EC_PPI;
      else if (wr_r && !bus.s_d)       res_ec = EC_PME;
      res_pa  = (res_ec == EC_NONE) ? tlb_pa : '0;
      res_idx = bus.s_found ? bus.s_index : '0;
    end
  end

  // result registers, loaded at the end of LOOKUP unless flushed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_pa_r    <= '0;
      rsp_ecode_r <= '0;
      rsp_index_r <= '0;
    end else if (state == LOOKUP && !flush) begin
      rsp_pa_r    <= res_pa;
      rsp_ecode_r <= res_ec;
      rsp_index_r <= res_idx;
    end
  end
endmodule

// File: tb/tb_addr_trans.sv
// Self-checking bench for addr_trans: directed cases plus randomized
// transactions compared against an arithmetic reference model.
module tb_addr_trans;
  localparam int unsigned TLBNUM = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        crmd_da;
  logic [1:0]  crmd_plv;
  logic [31:0] dmw0, dmw1;
  logic [9:0]  asid;

  int checks = 0;
  int failures = 0;

  addr_trans_if #(.TLBNUM(TLBNUM)) bus ();

  addr_trans #(.TLBNUM(TLBNUM)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .crmd_da  (crmd_da),
    .crmd_plv (crmd_plv),
    .dmw0     (dmw0),
    .dmw1     (dmw1),
    .asid     (asid),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit dmw_hit(input int unsigned va, input int unsigned dmw, input int unsigned plv);
    return ((va >> 29) == (dmw >> 29)) &&
           ((plv == 0 && (dmw & 1) != 0) || (plv == 3 && ((dmw >> 3) & 1) != 0));
  endfunction

  // reference translation computed from the current environment
  task automatic model(input int unsigned va, input bit wr,
                       output int unsigned pa, output int unsigned ec, output int unsigned idx);
    int unsigned plv = crmd_plv;
    pa = 0; ec = 0; idx = 0;
    if (crmd_da) begin
      pa = va;
    end else if (dmw_hit(va, dmw0, plv)) begin
      pa = ((dmw0 >> 25) % 8) * 32'h2000_0000 + va % 32'h2000_0000;
    end else if (dmw_hit(va, dmw1, plv)) begin
      pa = ((dmw1 >> 25) % 8) * 32'h2000_0000 + va % 32'h2000_0000;
    end else begin
      if (!bus.s_found)                    ec = 1;
      else if (!bus.s_v)                   ec = wr ? 3 : 2;
      else if (plv > int'(bus.s_plv))      ec = 4;
      else if (wr && !bus.s_d)             ec = 5;
      if (ec == 0) begin
        if (bus.s_ps == 6'd21) pa = (int'(bus.s_ppn) / 512) * 32'h20_0000 + va % 32'h20_0000;
        else                   pa = int'(bus.s_ppn) * 4096 + va % 4096;
      end
      idx = bus.s_found ? int'(bus.s_index) : 0;
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.req_ready && n < 20) begin
      tick();
      n++;
    end
    check("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
  endtask

  task automatic accept(input logic [31:0] va, input logic wr);
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_va    = va;
    bus.req_wr    = wr;
    tick();
    bus.req_valid = 1'b0;
    bus.req_va    = $urandom;
    bus.req_wr    = 1'($urandom);
  endtask

  // one full transaction, response held for 'hold' extra cycles
  task automatic run_txn(input logic [31:0] va, input logic wr, input int hold, input string tag);
    int unsigned epa, eec, eidx;
    model(va, wr, epa, eec, eidx);
    accept(va, wr);
    check({tag, "_lk_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
    check({tag, "_lk_ready"}, {31'd0, bus.req_ready}, 32'd0);
    check({tag, "_s_vppn"},   {13'd0, bus.s_vppn}, {13'd0, va[31:13]});
    check({tag, "_s_bit12"},  {31'd0, bus.s_va_bit12}, {31'd0, va[12]});
    check({tag, "_s_asid"},   {22'd0, bus.s_asid}, {22'd0, asid});
    tick();
    check({tag, "_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
    check({tag, "_pa"},    bus.rsp_pa, epa);
    check({tag, "_ecode"}, {29'd0, bus.rsp_ecode}, eec);
    check({tag, "_index"}, {28'd0, bus.rsp_index}, eidx);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
      check({tag, "_hold_ready"}, {31'd0, bus.req_ready}, 32'd0);
      check({tag, "_hold_pa"},    bus.rsp_pa, epa);
      check({tag, "_hold_ecode"}, {29'd0, bus.rsp_ecode}, eec);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check({tag, "_done_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
    check({tag, "_done_ready"}, {31'd0, bus.req_ready}, 32'd1);
  endtask

  task automatic set_tlb(input bit found, input int unsigned ps, input int unsigned ppn,
                         input bit v, input bit d, input int unsigned plv, input int unsigned idx);
    bus.s_found = found;
    bus.s_ps    = 6'(ps);
    bus.s_ppn   = 20'(ppn);
    bus.s_v     = v;
    bus.s_d     = d;
    bus.s_plv   = 2'(plv);
    bus.s_index = 4'(idx);
  endtask

  initial begin
    logic [31:0] va;
    reset = 1'b1; flush = 1'b0; crmd_da = 1'b0; crmd_plv = 2'd0;
    dmw0 = '0; dmw1 = '0; asid = 10'h155;
    bus.req_valid = 1'b0; bus.req_va = '0; bus.req_wr = 1'b0; bus.rsp_ready = 1'b0;
    set_tlb(0, 12, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_pa",    bus.rsp_pa, 32'd0);
    check("rst_ecode", {29'd0, bus.rsp_ecode}, 32'd0);
    check("rst_index", {28'd0, bus.rsp_index}, 32'd0);
    check("rst_vppn",  {13'd0, bus.s_vppn}, 32'd0);
    reset = 1'b0;
    tick();

    // direct address mode
    crmd_da = 1'b1;
    run_txn(32'h1234_5678, 1'b0, 0, "da");
    check("da_pa_const", bus.rsp_pa, 32'h1234_5678);

    // DMW0 hit independent of TLB
    crmd_da = 1'b0; crmd_plv = 2'd0; dmw0 = 32'h8000_0001; dmw1 = '0;
    set_tlb(0, 12, 0, 0, 0, 0, 0);
    run_txn(32'h9000_0010, 1'b0, 0, "dmw0");
    check("dmw0_pa_const", bus.rsp_pa, 32'h1000_0010);
    check("dmw0_ec_const", {29'd0, bus.rsp_ecode}, 32'd0);

    // TLB 4KB page: store to clean page, then load
    dmw0 = '0;
    set_tlb(1, 12, 32'h00ABC, 1, 0, 0, 5);
    run_txn(32'h0040_1ABC, 1'b1, 0, "pme");
    check("pme_ec_const",  {29'd0, bus.rsp_ecode}, 32'd5);
    check("pme_idx_const", {28'd0, bus.rsp_index}, 32'd5);
    check("pme_pa_const",  bus.rsp_pa, 32'd0);
    run_txn(32'h0040_1ABC, 1'b0, 4, "tlb_ld");
    check("tlb_ld_pa_const", bus.rsp_pa, 32'h00AB_CABC);

    // exception ladder
    set_tlb(0, 12, 32'h00ABC, 1, 1, 0, 5);
    run_txn(32'h0040_1ABC, 1'b0, 0, "tlbr");
    check("tlbr_ec_const", {29'd0, bus.rsp_ecode}, 32'd1);
    set_tlb(1, 12, 32'h00ABC, 0, 1, 0, 7);
    run_txn(32'h0040_1ABC, 1'b1, 0, "pis");
    check("pis_ec_const", {29'd0, bus.rsp_ecode}, 32'd3);
    set_tlb(1, 21, 32'h00ABC, 1, 1, 0, 7);
    crmd_plv = 2'd3;
    run_txn(32'h0040_1ABC, 1'b0, 0, "ppi");
    check("ppi_ec_const", {29'd0, bus.rsp_ecode}, 32'd4);

    // flush in RESP beats rsp_ready and req_valid
    crmd_plv = 2'd0;
    accept(32'h0012_3456, 1'b0);
    tick();
    check("fl_resp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    flush = 1'b1; bus.rsp_ready = 1'b1; bus.req_valid = 1'b1;
    #1;
    check("fl_req_ready_low", {31'd0, bus.req_ready}, 32'd0);
    tick();
    check("fl_valid_drop", {31'd0, bus.rsp_valid}, 32'd0);
    flush = 1'b0; bus.rsp_ready = 1'b0; bus.req_valid = 1'b0;
    #1;
    check("fl_idle", {31'd0, bus.req_ready}, 32'd1);

    // flush in LOOKUP discards the translation
    accept(32'h0012_3456, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_lk_valid0", {31'd0, bus.rsp_valid}, 32'd0);
    tick();
    check("fl_lk_valid1", {31'd0, bus.rsp_valid}, 32'd0);
    check("fl_lk_idle",   {31'd0, bus.req_ready}, 32'd1);

    // asynchronous reset during LOOKUP
    crmd_da = 1'b1;
    run_txn(32'hDEAD_BEEF, 1'b0, 0, "pre_rst");
    accept(32'hCAFE_F00D, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("arst_pa",    bus.rsp_pa, 32'd0);
    check("arst_ecode", {29'd0, bus.rsp_ecode}, 32'd0);
    check("arst_index", {28'd0, bus.rsp_index}, 32'd0);
    check("arst_vppn",  {13'd0, bus.s_vppn}, 32'd0);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("arst_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    end

    // randomized transactions
    for (int n = 0; n < 200; n++) begin
      va       = $urandom;
      crmd_da  = ($urandom_range(7) == 0);
      case ($urandom_range(3))
        0:       crmd_plv = 2'd0;
        1:       crmd_plv = 2'd3;
        default: crmd_plv = 2'($urandom);
      endcase
      dmw0 = $urandom;
      dmw1 = $urandom;
      if ($urandom_range(3) == 0) dmw0[31:29] = va[31:29];
      if ($urandom_range(3) == 0) dmw1[31:29] = va[31:29];
      asid = 10'($urandom);
      set_tlb($urandom_range(5) != 0, ($urandom_range(1) != 0) ? 12 : 21, $urandom,
              $urandom_range(5) != 0, 1'($urandom), $urandom_range(3), $urandom_range(TLBNUM-1));
      run_txn(va, 1'($urandom), $urandom_range(2), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
